// File: rtl/booth_arb_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM state encoding,
// default sizing and the requester-ID width helper.
package booth_arb_pkg;

  localparam int BMA_DEF_N       = 4;
  localparam int BMA_DEF_W       = 8;
  localparam int BMA_DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_BUSY  = 3'd3,
    S_RESP  = 3'd4,
    S_CLEAR = 3'd5
  } state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit scanning upward
// from ptr+1 with wrap, returned as a one-hot grant plus its index.
module rr_picker
  import booth_arb_pkg::*;
#(
  parameter int N = BMA_DEF_N
) (
  input  logic [N-1:0]         req,
  input  logic [id_w(N)-1:0]   ptr,
  output logic [N-1:0]         grant,
  output logic [id_w(N)-1:0]   idx,
  output logic                 any
);

  localparam int IDW = id_w(N);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = N; off >= 1; off--) begin
      k = (int'(ptr) + off) % N;
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = IDW'(k);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one Booth multiplier between N requesters.
// Optional BUSY-state abort after TIMEOUT cycles when BMA_TIMEOUT_EN is defined.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N       = BMA_DEF_N,
  parameter int W       = BMA_DEF_W,
  parameter int TIMEOUT = BMA_DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       a_in,
  input  logic [N*W-1:0]       b_in,
  output logic [N-1:0]         ack,
  output logic [W-1:0]         mul_m,
  output logic [W-1:0]         mul_q,
  output logic                 mul_start,
  output logic                 mul_clr,
  input  logic                 mul_done,
  input  logic [2*W-1:0]       mul_prod,
  output logic                 res_valid,
  output logic [id_w(N)-1:0]   res_id,
  output logic [2*W-1:0]       res_data,
  output logic                 res_err
);

  localparam int IDW = id_w(N);

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("booth_mul_arbiter: N must be 2..8 and TIMEOUT >= 1");
  end

  // Handshake: req[i] is a level held until the one-cycle ack[i]; operands are
  // captured on the grant, and results are strobed once by res_valid with no
  // backpressure.
  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [N-1:0]     pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

  rr_picker #(.N(N)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef BMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] busy_cnt;
  logic          timed_out;
  assign timed_out = (busy_cnt == TW'(TIMEOUT - 1));
`else
  assign res_err = 1'b0;
`endif

  // All outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      rr_ptr    <= IDW'(N - 1);
      cur_id    <= '0;
      ack       <= '0;
      mul_m     <= '0;
      mul_q     <= '0;
      mul_start <= 1'b0;
      mul_clr   <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
`ifdef BMA_TIMEOUT_EN
      res_err   <= 1'b0;
      busy_cnt  <= '0;
`endif
    end else begin
      ack       <= '0;
      mul_start <= 1'b0;
      mul_clr   <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_INIT: begin
          mul_clr <= 1'b1;
          state   <= S_IDLE;
        end
        S_IDLE: begin
          if (pick_any) begin
            mul_m     <= a_in[pick_idx*W +: W];
            mul_q     <= b_in[pick_idx*W +: W];
            cur_id    <= pick_idx;
            rr_ptr    <= pick_idx;
            ack       <= pick_grant;
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef BMA_TIMEOUT_EN
          busy_cnt <= '0;
`endif
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (mul_done) begin
            res_data  <= mul_prod;
            res_id    <= cur_id;
            res_valid <= 1'b1;
`ifdef BMA_TIMEOUT_EN
            res_err   <= 1'b0;
`endif
            state     <= S_RESP;
          end
`ifdef BMA_TIMEOUT_EN
          else if (timed_out) begin
            res_data  <= '0;
            res_id    <= cur_id;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          mul_clr <= 1'b1;
          state   <= S_CLEAR;
        end
        S_CLEAR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule
